// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 SDF FFT stages.
// Holds the stage state encoding, datapath widths and the delay-line sample type.
package fft_pkg;

  localparam int unsigned DATA_W  = 14;
  localparam int unsigned SR_W    = 15;
  localparam int unsigned WN_W    = 8;
  localparam int unsigned WN_FRAC = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    FIRST   = 2'b01,
    SECOND  = 2'b10,
    WAITING = 2'b11
  } state_t;

  typedef struct packed {
    logic signed [SR_W-1:0] r;
    logic signed [SR_W-1:0] i;
  } cplx_t;

  // Round half away from zero, then saturate to the signed twiddle range.
  function automatic int tw_quant(input real x);
    int v;
    if (x >= 0.0) v = int'($floor(x + 0.5));
    else          v = -int'($floor(-x + 0.5));
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v;
  endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Twiddle factor table W^k = exp(-j*2*pi*k/2^LOG2N), signed 2.6, built at elaboration.
// Lookup is purely combinational from idx.
module twiddle_rom
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = 5
) (
  input  logic        [LOG2N-1:0] idx,
  output logic signed [WN_W-1:0]  wn_r,
  output logic signed [WN_W-1:0]  wn_i
);

  localparam int unsigned SIZE  = 1 << LOG2N;
  localparam real         PI    = 3.14159265358979323846;
  localparam real         SCALE = real'(1 << WN_FRAC);

  logic signed [WN_W-1:0] rom_r [SIZE];
  logic signed [WN_W-1:0] rom_i [SIZE];

  for (genvar k = 0; k < SIZE; k++) begin : g_rom
    localparam real ANG = 2.0 * PI * real'(k) / real'(SIZE);
    localparam int  VR  = tw_quant(SCALE * $cos(ANG));
    localparam int  VI  = tw_quant(-SCALE * $sin(ANG));
    assign rom_r[k] = WN_W'(VR);
    assign rom_i[k] = WN_W'(VI);
  end

  assign wn_r = rom_r[idx];
  assign wn_i = rom_i[idx];

endmodule

// File: rtl/sdf_r2_stage.sv
// Radix-2 SDF FFT stage shell: N/2 delay line, four-state sequencer, twiddle ROM, output register.
// Optional macro SDF_FRAME_CNT_EN adds an 8-bit completed-frame counter output.
module sdf_r2_stage
  import fft_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TW_STRIDE = 1,
  parameter int unsigned LOG2N     = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_r,
  input  logic signed [DATA_W-1:0] in_i,
  output logic        [1:0]        bf_state,
  output logic signed [DATA_W-1:0] bf_A_r,
  output logic signed [DATA_W-1:0] bf_A_i,
  output logic signed [SR_W-1:0]   bf_B_r,
  output logic signed [SR_W-1:0]   bf_B_i,
  output logic signed [WN_W-1:0]   bf_WN_r,
  output logic signed [WN_W-1:0]   bf_WN_i,
  input  logic signed [SR_W-1:0]   bf_out_r,
  input  logic signed [SR_W-1:0]   bf_out_i,
  input  logic signed [SR_W-1:0]   bf_SR_r,
  input  logic signed [SR_W-1:0]   bf_SR_i,
`ifdef SDF_FRAME_CNT_EN
  output logic        [7:0]        frame_cnt,
`endif
  output logic                     out_valid,
  output logic signed [SR_W-1:0]   out_r,
  output logic signed [SR_W-1:0]   out_i
);

  localparam int unsigned CNT_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             shift;
  logic             out_load;
  logic             frame_done;
  logic [LOG2N-1:0] tw_idx;
  cplx_t            line_q [DEPTH];

  assign in_ready = (state_q == WAITING) || (state_q == FIRST);
  assign accept   = in_valid && in_ready;
  assign bf_state = state_q;
  assign bf_A_r   = in_r;
  assign bf_A_i   = in_i;
  assign bf_B_r   = line_q[0].r;
  assign bf_B_i   = line_q[0].i;

  // Sequencer next state; SECOND free-runs, WAITING/FIRST advance only on accepted samples.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift      = 1'b0;
    out_load   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = WAITING;
          cnt_d   = '0;
        end
      end
      WAITING, FIRST: begin
        if (accept) begin
          shift    = 1'b1;
          out_load = (state_q == FIRST);
          if (cnt_q == CNT_LAST) begin
            state_d = (state_q == FIRST) ? SECOND : FIRST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SECOND: begin
        shift    = 1'b1;
        out_load = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d    = en ? WAITING : IDLE;
          cnt_d      = '0;
          frame_done = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Delay line: push at the tail, head (index 0) is the oldest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) line_q[k] <= '0;
    end else if (shift) begin
      for (int k = 0; k < DEPTH - 1; k++) line_q[k] <= line_q[k+1];
      line_q[DEPTH-1] <= '{r: bf_SR_r, i: bf_SR_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
    end else begin
      out_valid <= out_load;
      if (out_load) begin
        out_r <= bf_out_r;
        out_i <= bf_out_i;
      end
    end
  end

  // Twiddle index only walks during SECOND; elsewhere W^0.
  always_comb begin
    tw_idx = '0;
    if (state_q == SECOND) tw_idx = LOG2N'(32'(cnt_q) * TW_STRIDE);
  end

  twiddle_rom #(.LOG2N(LOG2N)) u_twiddle_rom (
    .idx  (tw_idx),
    .wn_r (bf_WN_r),
    .wn_i (bf_WN_i)
  );

`ifdef SDF_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             frame_cnt <= '0;
    else if (frame_done) frame_cnt <= frame_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Self-checking bench for sdf_r2_stage with a behavioural radix-2 butterfly and a scoreboard.
// Frame counter checks are included only when SDF_FRAME_CNT_EN is defined.
module tb_sdf_r2_stage;
  import fft_pkg::*;

  localparam int DEPTH = 16;
  localparam int N     = 2 * DEPTH;

  logic                     clk, rst, en, in_valid, in_ready, out_valid;
  logic signed [DATA_W-1:0] in_r, in_i, bf_A_r, bf_A_i;
  logic        [1:0]        bf_state;
  logic signed [SR_W-1:0]   bf_B_r, bf_B_i, bf_out_r, bf_out_i, bf_SR_r, bf_SR_i, out_r, out_i;
  logic signed [WN_W-1:0]   bf_WN_r, bf_WN_i;
`ifdef SDF_FRAME_CNT_EN
  logic        [7:0]        frame_cnt;
`endif

  sdf_r2_stage #(.DEPTH(DEPTH), .TW_STRIDE(1), .LOG2N(5)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_i(in_i), .bf_state(bf_state),
    .bf_A_r(bf_A_r), .bf_A_i(bf_A_i), .bf_B_r(bf_B_r), .bf_B_i(bf_B_i),
    .bf_WN_r(bf_WN_r), .bf_WN_i(bf_WN_i), .bf_out_r(bf_out_r), .bf_out_i(bf_out_i),
    .bf_SR_r(bf_SR_r), .bf_SR_i(bf_SR_i),
`ifdef SDF_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .out_valid(out_valid), .out_r(out_r), .out_i(out_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural butterfly: FIRST sums/differences, SECOND rotates the stored difference.
  int pr, pi;
  always_comb begin
    pr = 0;
    pi = 0;
    bf_out_r = '0;
    bf_out_i = '0;
    bf_SR_r  = 15'(int'(bf_A_r));
    bf_SR_i  = 15'(int'(bf_A_i));
    case (bf_state)
      2'b01: begin
        bf_out_r = 15'(int'(bf_A_r) + int'(bf_B_r));
        bf_out_i = 15'(int'(bf_A_i) + int'(bf_B_i));
        bf_SR_r  = 15'(int'(bf_B_r) - int'(bf_A_r));
        bf_SR_i  = 15'(int'(bf_B_i) - int'(bf_A_i));
      end
      2'b10: begin
        pr = (int'(bf_B_r) * int'(bf_WN_r) - int'(bf_B_i) * int'(bf_WN_i)) >>> 6;
        pi = (int'(bf_B_r) * int'(bf_WN_i) + int'(bf_B_i) * int'(bf_WN_r)) >>> 6;
        bf_out_r = 15'(pr);
        bf_out_i = 15'(pi);
        bf_SR_r  = '0;
        bf_SR_i  = '0;
      end
      default: ;
    endcase
  end

  typedef struct {
    int r;
    int i;
  } exp_t;

  exp_t q[$];
  int   wr[N], wi[N];
  int   xr[N], xi[N];

  function automatic int rnd(input real x);
    if (x >= 0.0) return int'($floor(x + 0.5));
    return -int'($floor(-x + 0.5));
  endfunction

  // Reference frame result: bin pairs in FIRST, twiddled differences in SECOND.
  task automatic push_expected();
    exp_t e;
    int dr, di;
    for (int n = 0; n < DEPTH; n++) begin
      e.r = xr[n] + xr[n+DEPTH];
      e.i = xi[n] + xi[n+DEPTH];
      q.push_back(e);
    end
    for (int k = 0; k < DEPTH; k++) begin
      dr = xr[k] - xr[k+DEPTH];
      di = xi[k] - xi[k+DEPTH];
      e.r = (dr * wr[k] - di * wi[k]) >>> 6;
      e.i = (dr * wi[k] + di * wr[k]) >>> 6;
      q.push_back(e);
    end
  endtask

  task automatic fill_ramp();
    for (int n = 0; n < N; n++) begin
      xr[n] = n * 256;
      xi[n] = 0;
    end
  endtask

  task automatic fill_rand();
    for (int n = 0; n < N; n++) begin
      xr[n] = int'($urandom_range(0, 8000)) - 4000;
      xi[n] = int'($urandom_range(0, 8000)) - 4000;
    end
  endtask

  // Drive one frame from negedge to negedge; optional 3-cycle stalls before samples sa/sb.
  task automatic send_frame(input int sa, input int sb, input int en_off, input int stop_at,
                            output int first_wait);
    int w;
    first_wait = 0;
    for (int n = 0; n < stop_at; n++) begin
      if (n == sa || n == sb) begin
        for (int s = 0; s < 3; s++) begin
          in_valid = 1'b0;
          @(negedge clk);
          chk($sformatf("stall_state[%0d]", n), int'(bf_state), (n < DEPTH) ? 3 : 1);
          if (n >= DEPTH) chk($sformatf("stall_ov[%0d]", n), int'(out_valid), 0);
        end
      end
      if (n == en_off) en = 1'b0;
      in_valid = 1'b1;
      in_r     = 14'(xr[n]);
      in_i     = 14'(xi[n]);
      w = 0;
      while (!in_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (w >= 200) chk("accept_timeout", w, 0);
      if (n == 0) begin
        first_wait = w;
        chk("frame_start_state", int'(bf_state), 3);
      end
      if (n < DEPTH) begin
        chk($sformatf("wait_bB_r[%0d]", n), int'(bf_B_r), 0);
        chk($sformatf("wait_bB_i[%0d]", n), int'(bf_B_i), 0);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Scoreboard consumer; outputs must also hold between valid cycles.
  int   last_r = 0, last_i = 0, oidx = 0;
  exp_t me;
  always @(negedge clk) begin
    if (rst) begin
      last_r = 0;
      last_i = 0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        me = q.pop_front();
        chk($sformatf("out_r[%0d]", oidx), int'(out_r), me.r);
        chk($sformatf("out_i[%0d]", oidx), int'(out_i), me.i);
        last_r = me.r;
        last_i = me.i;
        oidx++;
      end
    end else begin
      chk("hold_r", int'(out_r), last_r);
      chk("hold_i", int'(out_i), last_i);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int fw;
  initial begin
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_r = '0; in_i = '0;
    for (int k = 0; k < N; k++) begin
      wr[k] = rnd(64.0 * $cos(2.0 * 3.14159265358979 * real'(k) / 32.0));
      wi[k] = rnd(-64.0 * $sin(2.0 * 3.14159265358979 * real'(k) / 32.0));
    end
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_state", int'(bf_state), 0);
    chk("rst_out_r", int'(out_r), 0);
    chk("rst_out_i", int'(out_i), 0);
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("idle_no_en", int'(bf_state), 0);
    en = 1'b1;

    // Partial ramp frame, then asynchronous reset in the middle of FIRST.
    fill_ramp(); push_expected();
    send_frame(-1, -1, -1, 21, fw);
    chk("pre_rst_state", int'(bf_state), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_state", int'(bf_state), 0);
`ifdef SDF_FRAME_CNT_EN
    chk("midrst_frame_cnt", int'(frame_cnt), 0);
`endif
    q.delete();
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk);

    // Clean ramp frame, then a random frame that waits out SECOND with in_valid held high.
    fill_ramp(); push_expected();
    send_frame(-1, -1, -1, N, fw);
    fill_rand(); push_expected();
    send_frame(-1, -1, -1, N, fw);
    chk("second_ready_low_cycles", fw, 16);

    // Ramp frame with stalls in WAITING and FIRST.
    fill_ramp(); push_expected();
    send_frame(5, 21, -1, N, fw);
    chk("second_ready_low_cycles2", fw, 16);

    // Drop en during FIRST: frame completes, then the stage parks in IDLE.
    fill_rand(); push_expected();
    send_frame(-1, -1, 20, N, fw);
    repeat (15) @(negedge clk);
    chk("en_off_still_second", int'(bf_state), 2);
    @(negedge clk);
    chk("en_off_idle", int'(bf_state), 0);
    chk("en_off_ready", int'(in_ready), 0);
`ifdef SDF_FRAME_CNT_EN
    chk("frame_cnt", int'(frame_cnt), 4);
`endif
    repeat (3) @(negedge clk);
    chk("idle_stays", int'(bf_state), 0);
    en = 1'b1;
    @(negedge clk);
    chk("reen_waiting", int'(bf_state), 3);

    repeat (5) @(negedge clk);
    chk("drain", q.size(), 0);
    chk("out_count", oidx, 5 + 4 * N);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
